// File: rtl/dual_priority_grant_decoder.sv
// Turns a pair of 4-bit priority codes into two sequential one-hot grants, each held HOLD cycles.
// Optional macro DECODE_ERR_EN adds err/err_cnt reporting for malformed code pairs.
module dual_priority_grant_decoder #(
    parameter int N_REQ = 12,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       prior_1,
    input  logic [3:0]       prior_2,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             busy,
    output logic             done
`ifdef DECODE_ERR_EN
    ,
    output logic             err,
    output logic [7:0]       err_cnt
`endif
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, G1, G2, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [3:0]       c1, c2;
    logic             take;

    function automatic logic code_ok(input logic [3:0] c);
        return (c != 4'd0) && (int'(c) <= N_REQ);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [3:0] c);
        logic [N_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (c == 4'(i + 1)) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign take        = in_valid & in_ready;
    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign grant_valid = |grant;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                grant_nxt = '0;
                if (take) begin
                    if (code_ok(prior_1)) begin
                        state_nxt = G1;
                        grant_nxt = onehot(prior_1);
                    end else if (code_ok(prior_2)) begin
                        state_nxt = G2;
                        grant_nxt = onehot(prior_2);
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            G1: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (code_ok(c2) && (c2 != c1)) begin
                        state_nxt = G2;
                        grant_nxt = onehot(c2);
                    end else begin
                        state_nxt = DONE;
                        grant_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            G2: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                    grant_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                grant_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            grant <= '0;
            c1    <= '0;
            c2    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
            if (take) begin
                c1 <= prior_1;
                c2 <= prior_2;
            end
        end
    end

`ifdef DECODE_ERR_EN
    logic err_q;

    function automatic logic malformed(input logic [3:0] a, input logic [3:0] b);
        logic bad_code;
        bad_code = ((a != 4'd0) && !code_ok(a)) || ((b != 4'd0) && !code_ok(b));
        return bad_code
            || ((a == 4'd0) && (b != 4'd0))
            || ((a == b) && (a != 4'd0))
            || (code_ok(a) && code_ok(b) && (b > a));
    endfunction

    assign err = done & err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (take) err_q <= malformed(prior_1, prior_2);
            if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_priority_grant_decoder.sv
// Table-driven bench for dual_priority_grant_decoder with hand-written reset-abort sequence.
module tb_dual_priority_grant_decoder;

    localparam int N_REQ = 12;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       prior_1, prior_2;
    logic [N_REQ-1:0] grant;
    logic             grant_valid, busy, done;
`ifdef DECODE_ERR_EN
    logic             err;
    logic [7:0]       err_cnt;
    int               err_model = 0;
`endif

    int checks   = 0;
    int failures = 0;

    dual_priority_grant_decoder #(.N_REQ(N_REQ), .HOLD(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prior_1    (prior_1),
        .prior_2    (prior_2),
        .grant      (grant),
        .grant_valid(grant_valid),
        .busy       (busy),
        .done       (done)
`ifdef DECODE_ERR_EN
        ,
        .err        (err),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       p1;
        logic [3:0]       p2;
        logic [N_REQ-1:0] ga;
        logic [N_REQ-1:0] gb;
        int               k;
        bit               err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves at the negedge of the first IDLE cycle afterwards.
    task automatic run_vec(input int id, input vec_t v);
        int last;
        logic [N_REQ-1:0] exp_g;
        in_valid = 1'b1;
        prior_1  = v.p1;
        prior_2  = v.p2;
        @(posedge clk);
        #1;
        prior_1 = 4'($urandom_range(0, 15));
        prior_2 = 4'($urandom_range(0, 15));
        last = v.k * HOLD + 1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n <= HOLD && v.k >= 1)          exp_g = v.ga;
            else if (n <= 2 * HOLD && v.k == 2) exp_g = v.gb;
            else                                exp_g = '0;
            check($sformatf("v%0d_c%0d_grant", id, n), 32'(grant), 32'(exp_g));
            check($sformatf("v%0d_c%0d_gvalid", id, n), 32'(grant_valid), 32'(exp_g != '0));
            check($sformatf("v%0d_c%0d_done", id, n), 32'(done), 32'(n == last));
            check($sformatf("v%0d_c%0d_busy", id, n), 32'(busy), 32'd1);
            check($sformatf("v%0d_c%0d_ready", id, n), 32'(in_ready), 32'd0);
`ifdef DECODE_ERR_EN
            check($sformatf("v%0d_c%0d_err", id, n), 32'(err), 32'((n == last) && v.err));
`endif
            if (n == last) in_valid = 1'b0;
        end
`ifdef DECODE_ERR_EN
        if (v.err && err_model < 255) err_model++;
`endif
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", id), 32'(in_ready), 32'd1);
        check($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
        check($sformatf("v%0d_idle_grant", id), 32'(grant), 32'd0);
        check($sformatf("v%0d_idle_done", id), 32'(done), 32'd0);
`ifdef DECODE_ERR_EN
        check($sformatf("v%0d_err_cnt", id), 32'(err_cnt), 32'(err_model));
`endif
    endtask

    initial begin
        vecs[0]  = '{p1: 4'd12, p2: 4'd3,  ga: 12'h800, gb: 12'h004, k: 2, err: 1'b0};
        vecs[1]  = '{p1: 4'd1,  p2: 4'd0,  ga: 12'h001, gb: 12'h000, k: 1, err: 1'b0};
        vecs[2]  = '{p1: 4'd0,  p2: 4'd0,  ga: 12'h000, gb: 12'h000, k: 0, err: 1'b0};
        vecs[3]  = '{p1: 4'd5,  p2: 4'd5,  ga: 12'h010, gb: 12'h000, k: 1, err: 1'b1};
        vecs[4]  = '{p1: 4'd14, p2: 4'd2,  ga: 12'h002, gb: 12'h000, k: 1, err: 1'b1};
        vecs[5]  = '{p1: 4'd3,  p2: 4'd12, ga: 12'h004, gb: 12'h800, k: 2, err: 1'b1};
        vecs[6]  = '{p1: 4'd0,  p2: 4'd7,  ga: 12'h040, gb: 12'h000, k: 1, err: 1'b1};
        vecs[7]  = '{p1: 4'd7,  p2: 4'd15, ga: 12'h040, gb: 12'h000, k: 1, err: 1'b1};
        vecs[8]  = '{p1: 4'd13, p2: 4'd0,  ga: 12'h000, gb: 12'h000, k: 0, err: 1'b1};
        vecs[9]  = '{p1: 4'd11, p2: 4'd10, ga: 12'h400, gb: 12'h200, k: 2, err: 1'b0};
        vecs[10] = '{p1: 4'd2,  p2: 4'd1,  ga: 12'h002, gb: 12'h001, k: 2, err: 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        prior_1  = '0;
        prior_2  = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Pair (9,4) aborted by reset during G2.
        in_valid = 1'b1;
        prior_1  = 4'd9;
        prior_2  = 4'd4;
        @(posedge clk);
        #1;
        prior_1 = 4'd6;
        prior_2 = 4'd1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check($sformatf("abort_c%0d_grant", n), 32'(grant), (n <= HOLD) ? 32'h100 : 32'h008);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_grant_async", 32'(grant), 32'd0);
        check("abort_busy_async", 32'(busy), 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("abort_hold%0d_done", n), 32'(done), 32'd0);
            check($sformatf("abort_hold%0d_grant", n), 32'(grant), 32'd0);
        end
        reset = 1'b0;
`ifdef DECODE_ERR_EN
        err_model = 0;
`endif
        @(negedge clk);
        check("abort_release_ready", 32'(in_ready), 32'd1);
        check("abort_release_done", 32'(done), 32'd0);
`ifdef DECODE_ERR_EN
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
`endif
        run_vec(10, vecs[10]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
